// File: rtl/conf_int_add_pkg.sv
// Shared constants and helpers for the configurable approximate adder.
package conf_int_add_pkg;

  localparam int MAX_W = 64;

  typedef logic [1:0] state_t;

  localparam state_t RUN   = 2'd0;
  localparam state_t DRAIN = 2'd1;
  localparam state_t APPLY = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] loa_mask(input int k);
    return ~({MAX_W{1'b1}} << k);
  endfunction

  function automatic logic [MAX_W-1:0] max_pos(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w + 1);
  endfunction

  function automatic logic [MAX_W-1:0] max_neg(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/conf_int_add__loa_seg.sv
// Half-width segment: OR over masked low bits, exact add above them.
module conf_int_add__loa_seg #(
  parameter int H = 16
) (
  input  logic [H-1:0] x,
  input  logic [H-1:0] y,
  input  logic [H-1:0] m,
  input  logic         cin,
  output logic [H-1:0] s,
  output logic         cout
);

  logic [H-1:0] top;
  logic [H:0]   gen;
  logic [H:0]   sum;

  // top marks the highest approximated bit; its AND feeds the exact part
  assign top = m ^ (m >> 1);
  assign gen = {x & y & top, 1'b0};
  assign sum = {1'b0, x & ~m} + {1'b0, y & ~m} + gen
             + {{H{1'b0}}, cin & ~|m};

  assign s    = ((x | y) & m) | (sum[H-1:0] & ~m);
  assign cout = sum[H];

endmodule

// File: rtl/conf_int_add__pipelined_cfg__arch_agnos.sv
// Two-stage LOA/exact adder with run-time approximation level and drain FSM.
module conf_int_add__pipelined_cfg__arch_agnos
  import conf_int_add_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int OP_BITWIDTH        = 32,
  parameter int SATURATE           = 0
) (
  input  logic                                   clk,
  input  logic                                   racc,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]          a,
  input  logic [DATA_PATH_BITWIDTH-1:0]          b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0]          d,
  output logic                                   ovf,
  input  logic                                   cfg_req,
  input  logic [clog2(DATA_PATH_BITWIDTH)-1:0]   cfg_apx_bits,
  output logic                                   cfg_ack,
  output logic [clog2(DATA_PATH_BITWIDTH)-1:0]   cur_apx_bits
);

  localparam int W  = DATA_PATH_BITWIDTH;
  localparam int H  = W / 2;
  localparam int KW = clog2(W);

  localparam logic [KW-1:0] K_RST   = KW'(W - OP_BITWIDTH);
  localparam logic [W-1:0]  MAX_POS = W'(max_pos(W));
  localparam logic [W-1:0]  MAX_NEG = W'(max_neg(W));

  state_t        state;
  logic          req_seen;
  logic          take;
  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic [W-1:0]  mask;
  logic [KW-1:0] k_clamp;

  logic [H-1:0]  lo_s;
  logic          lo_co;
  logic [H-1:0]  s1_lo;
  logic [H-1:0]  s1_a;
  logic [H-1:0]  s1_b;
  logic [H-1:0]  s1_m;
  logic          s1_c;
  logic [H-1:0]  hi_s;
  logic          hi_co;
  logic          ovf_raw;
  logic [W-1:0]  d_nxt;

  assign take    = (state == RUN) && cfg_req && !req_seen;
  assign s2_adv  = !s2_valid || out_ready;
  assign s1_adv  = s2_adv || !s1_valid;
  assign in_ready = !racc && (state == RUN) && !take && s1_adv;
  assign accept  = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign mask    = W'(loa_mask(int'(cur_apx_bits)));
  assign k_clamp = (int'(cfg_apx_bits) > W - 1) ? KW'(W - 1)
                                                 : cfg_apx_bits;

  conf_int_add__loa_seg #(.H(H)) u_lo (
    .x    (a[H-1:0]),
    .y    (b[H-1:0]),
    .m    (mask[H-1:0]),
    .cin  (1'b0),
    .s    (lo_s),
    .cout (lo_co)
  );

  conf_int_add__loa_seg #(.H(H)) u_hi (
    .x    (s1_a),
    .y    (s1_b),
    .m    (s1_m),
    .cin  (s1_c),
    .s    (hi_s),
    .cout (hi_co)
  );

  // with equal operand signs the carry-out equals that sign
  assign ovf_raw = (s1_a[H-1] == s1_b[H-1]) && (hi_co != hi_s[H-1]);

  always_comb begin
    d_nxt = {hi_s, s1_lo};
    if (SATURATE != 0 && ovf_raw)
      d_nxt = s1_a[H-1] ? MAX_NEG : MAX_POS;
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_m     <= '0;
      s1_c     <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_lo <= lo_s;
        s1_a  <= a[W-1:H];
        s1_b  <= b[W-1:H];
        s1_m  <= mask[W-1:H];
        s1_c  <= lo_co;
      end
    end
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      s2_valid <= 1'b0;
      d        <= '0;
      ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d   <= d_nxt;
        ovf <= ovf_raw;
      end
    end
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state        <= RUN;
      cur_apx_bits <= K_RST;
      req_seen     <= 1'b0;
      cfg_ack      <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      if (!cfg_req) req_seen <= 1'b0;
      unique case (state)
        RUN:
          if (take) state <= DRAIN;
        DRAIN:
          if (!s1_valid && !s2_valid) state <= APPLY;
        APPLY: begin
          cur_apx_bits <= k_clamp;
          cfg_ack      <= 1'b1;
          req_seen     <= 1'b1;
          state        <= RUN;
        end
        default:
          state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_int_add__pipelined_cfg__arch_agnos.sv
// Directed bench for the configurable approximate adder (wrap and saturate).
module tb_conf_int_add__pipelined_cfg__arch_agnos;

  logic        clk = 1'b0;
  logic        racc;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cfg_req;
  logic [4:0]  cfg_apx_bits;

  logic        in_ready, out_valid, ovf, cfg_ack;
  logic [31:0] d;
  logic [4:0]  cur_apx_bits;

  logic        in_ready_s, out_valid_s, ovf_s, cfg_ack_s;
  logic [31:0] d_s;
  logic [4:0]  cur_apx_bits_s;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  conf_int_add__pipelined_cfg__arch_agnos #(
    .DATA_PATH_BITWIDTH(32), .OP_BITWIDTH(32), .SATURATE(0)
  ) dut (
    .clk(clk), .racc(racc), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .ovf(ovf), .cfg_req(cfg_req), .cfg_apx_bits(cfg_apx_bits),
    .cfg_ack(cfg_ack), .cur_apx_bits(cur_apx_bits)
  );

  conf_int_add__pipelined_cfg__arch_agnos #(
    .DATA_PATH_BITWIDTH(32), .OP_BITWIDTH(32), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .racc(racc), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .d(d_s), .ovf(ovf_s), .cfg_req(cfg_req), .cfg_apx_bits(cfg_apx_bits),
    .cfg_ack(cfg_ack_s), .cur_apx_bits(cur_apx_bits_s)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic beat(input string tag, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] ed,
                      input logic eo, input logic [31:0] es);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_dsat"}, d_s, es);
    chk({tag, "_ovfsat"}, ovf_s, eo);
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [4:0] k);
    int n;
    n = 0;
    cfg_apx_bits = k; cfg_req = 1'b1;
    #1 chk("cfg_rdy_drop", in_ready, 0);
    while (!cfg_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cfg_ack_lat", n, 3);
    chk("cfg_cur", cur_apx_bits, k);
    cfg_req = 1'b0;
    @(posedge clk); #1;
    chk("cfg_ack_pulse", cfg_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q [10];
    logic [31:0] dr_q [2];
    logic [31:0] held;
    logic        stalled;
    logic        saw_block;
    int sent, got, occ, acks;

    racc = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cfg_req = 1'b0; cfg_apx_bits = '0;
    #2;
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_cur", cur_apx_bits, 0);
    #20 racc = 1'b0;
    #1 chk("rel_rdy", in_ready, 1);
    @(posedge clk); #1;

    beat("k0_pos", 32'd5, 32'd7, 32'd12, 1'b0, 32'd12);
    beat("k0_neg", 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFE, 1'b0,
         32'hFFFF_FFFE);
    beat("ovf_pos", 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1,
         32'h7FFF_FFFF);
    beat("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1,
         32'h8000_0000);

    // streaming with a 3-cycle output stall
    for (int i = 0; i < 10; i++) exp_q[i] = (i * 7 + 3) + i * 1000;
    sent = 0; got = 0; stalled = 1'b0; saw_block = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid = (sent < 10);
      a = sent * 7 + 3;
      b = sent * 1000;
      occ = sent - got;
      #1;
      if (stalled) begin
        chk("st_hold_v", out_valid, 1);
        chk("st_hold_d", d, held);
      end
      chk("st_rdy", in_ready, (out_ready || occ < 2) ? 1 : 0);
      if (!in_ready) saw_block = 1'b1;
      stalled = out_valid && !out_ready;
      held = d;
      if (out_valid && out_ready) begin
        chk("st_d", d, exp_q[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("st_count", got, 10);
    chk("st_blocked", saw_block, 1);

    cfg(5'd4);
    beat("k4_or", 32'h0000_000F, 32'h0000_0001, 32'h0000_000F, 1'b0,
         32'h0000_000F);
    beat("k4_cin", 32'h0000_0008, 32'h0000_0008, 32'h0000_0018, 1'b0,
         32'h0000_0018);
    beat("k4_neg", 32'hFFFF_FFF7, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0,
         32'hFFFF_FFFF);
    cfg(5'd16);
    beat("k16_mid", 32'h0000_8000, 32'h0000_8000, 32'h0001_8000, 1'b0,
         32'h0001_8000);
    cfg(5'd20);
    beat("k20_hi", 32'h0008_0001, 32'h0008_0002, 32'h0018_0003, 1'b0,
         32'h0018_0003);

    // reconfigure to k=8 with two beats in flight under backpressure
    dr_q[0] = 32'h0018_0003;
    dr_q[1] = 32'h0000_FFFF;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h0008_0001; b = 32'h0008_0002;
    #1 chk("dr_rdy0", in_ready, 1);
    @(posedge clk); #1;
    a = 32'h0000_0F0F; b = 32'h0000_F0F1;
    #1 chk("dr_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_apx_bits = 5'd8; cfg_req = 1'b1;
    #1 chk("dr_rdy_req", in_ready, 0);
    chk("dr_ov", out_valid, 1);
    @(posedge clk); #1;
    chk("dr_hold", d, dr_q[0]);
    chk("dr_rdy_drain", in_ready, 0);
    out_ready = 1'b1;
    got = 0; acks = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid && out_ready) begin
        if (got < 2) chk("dr_res", d, dr_q[got]);
        else chk("dr_extra", got, 2);
        got++;
      end
      if (cfg_ack) acks++;
      if (acks == 0) chk("dr_block", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("dr_acks", acks, 1);
    chk("dr_got", got, 2);
    chk("dr_cur", cur_apx_bits, 8);
    cfg_req = 1'b0;
    @(posedge clk); #1;
    beat("k8_new", 32'h0000_0180, 32'h0000_0080, 32'h0000_0280, 1'b0,
         32'h0000_0280);

    // reset while draining with a beat in S2
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_apx_bits = 5'd12; cfg_req = 1'b1;
    @(posedge clk); #1;
    chk("rs_ov_pre", out_valid, 1);
    chk("rs_rdy_pre", in_ready, 0);
    racc = 1'b1;
    #1;
    chk("rs_ov", out_valid, 0);
    chk("rs_cur", cur_apx_bits, 0);
    chk("rs_ack", cfg_ack, 0);
    chk("rs_rdy", in_ready, 0);
    cfg_req = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    racc = 1'b0;
    acks = 0;
    @(posedge clk); #1;
    chk("rs_rdy_rel", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      if (cfg_ack) acks++;
      @(posedge clk); #1;
    end
    chk("rs_no_ack", acks, 0);
    chk("rs_cur_keep", cur_apx_bits, 0);
    chk("rs_ov_post", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
